mem_access_stage: RTL and testbench

Consumer of the EX/MEM pipeline register in the five-stage core: it takes the registered ALU result, store data, destination register and M/WB control bits and performs the data-memory access over a req/ack handshake. It holds the pipeline with `stall` while an access is outstanding. It then loads the MEM/WB register that feeds write-back.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_wb_reg.sv | 39 +++
 rtl/mem_access_stage.sv | 144 ++++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants, FSM state and MEM/WB entry type for the memory stage
package mem_stage_pkg;

    localparam int M_READ      = 0;
    localparam int M_WRITE     = 1;
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_REG_W  = 5;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic [ENTRY_REG_W-1:0]  reg_dest;
        logic [ENTRY_DATA_W-1:0] value;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register; load takes a new entry, otherwise a bubble is inserted
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              valid_d,
    input  logic              reg_write_d,
    input  logic [REG_W-1:0]  reg_dest_d,
    input  logic [DATA_W-1:0] value_d,
    output logic              valid,
    output logic              reg_write,
    output logic [REG_W-1:0]  reg_dest,
    output logic [DATA_W-1:0] value
);

    // A bubble clears only the qualifiers; dest/value hold their last contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            reg_write <= 1'b0;
            reg_dest  <= '0;
            value     <= '0;
        end else if (load) begin
            valid     <= valid_d;
            reg_write <= reg_write_d;
            reg_dest  <= reg_dest_d;
            value     <= value_d;
        end else begin
            valid     <= 1'b0;
            reg_write <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - data-memory access stage with req/ack handshake and MEM/WB load; optional ALIGN_CHECK_EN
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic [3:0]        ctrl_m_in,
    input  logic [1:0]        ctrl_wb_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_reg_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              misalign
);

    state_t            state;
    logic [DATA_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_we;
    logic [REG_W-1:0]  pend_dest;
    logic              pend_reg_write;
    logic              pend_mem_to_reg;

    logic mem_op, bad_align, start, in_access, done;
    logic unused_ctrl;

    assign unused_ctrl = ^ctrl_m_in[3:2];
    assign mem_op      = valid_in & (ctrl_m_in[M_READ] | ctrl_m_in[M_WRITE]);

`ifdef ALIGN_CHECK_EN
    assign bad_align = mem_op & (result_in[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    assign start     = mem_op & ~bad_align;
    assign in_access = (state == ACCESS);
    assign done      = in_access & mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            acc_addr        <= '0;
            acc_wdata       <= '0;
            acc_we          <= 1'b0;
            pend_dest       <= '0;
            pend_reg_write  <= 1'b0;
            pend_mem_to_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= ACCESS;
                        acc_addr        <= result_in;
                        acc_wdata       <= write_data_in;
                        acc_we          <= ctrl_m_in[M_WRITE];
                        pend_dest       <= reg_dest_in;
                        pend_reg_write  <= ctrl_wb_in[WB_REGWRITE];
                        pend_mem_to_reg <= ctrl_wb_in[WB_MEMTOREG];
                    end
                end
                ACCESS: begin
                    if (mem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so an in-flight stall is released the moment reset hits
    assign stall     = ~rst & ((~in_access & start) | (in_access & ~mem_ack));
    assign mem_req   = in_access;
    assign mem_we    = acc_we;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;

    logic              wb_load;
    logic              wb_valid_d;
    logic              wb_reg_write_d;
    logic [REG_W-1:0]  wb_reg_dest_d;
    logic [DATA_W-1:0] wb_value_d;

    always_comb begin
        wb_load        = 1'b0;
        wb_valid_d     = valid_in;
        wb_reg_write_d = valid_in & ctrl_wb_in[WB_REGWRITE] & ~bad_align;
        wb_reg_dest_d  = reg_dest_in;
        wb_value_d     = result_in;
        if (done) begin
            wb_load        = 1'b1;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = pend_reg_write & ~acc_we;
            wb_reg_dest_d  = pend_dest;
            wb_value_d     = pend_mem_to_reg ? mem_rdata : acc_addr;
        end else if (~in_access & ~start) begin
            wb_load = 1'b1;
        end
    end

    mem_wb_reg #(
        .DATA_W(DATA_W),
        .REG_W (REG_W)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (wb_load),
        .valid_d    (wb_valid_d),
        .reg_write_d(wb_reg_write_d),
        .reg_dest_d (wb_reg_dest_d),
        .value_d    (wb_value_d),
        .valid      (wb_valid),
        .reg_write  (wb_reg_write),
        .reg_dest   (wb_reg_dest),
        .value      (wb_value)
    );

`ifdef ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= ~in_access & bad_align;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench with random entries, a reference memory and a responder
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] result_in = '0;
    logic [31:0] write_data_in = '0;
    logic [4:0]  reg_dest_in = '0;
    logic [3:0]  ctrl_m_in = '0;
    logic [1:0]  ctrl_wb_in = '0;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_reg_write, misalign;
    logic [4:0]  wb_reg_dest;
    logic [31:0] wb_value;

    mem_access_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .result_in(result_in),
        .write_data_in(write_data_in), .reg_dest_in(reg_dest_in),
        .ctrl_m_in(ctrl_m_in), .ctrl_wb_in(ctrl_wb_in), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_reg_dest(wb_reg_dest), .wb_value(wb_value), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int          total_cnt = 0;
    int          pass_cnt = 0;
    int          last_stall = 0;
    int          fixed_delay = -1;
    bit          resp_en = 1'b1;
    mem_wb_t     exp_q[$];
    bit          mis_q[$];
    acc_t        acc_q[$];
    logic [31:0] mem[logic [31:0]];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [31:0] model_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Expected results come from the architectural meaning of the entry
    task automatic issue(input logic v, input logic [31:0] res, input logic [31:0] wd,
                         input logic [4:0] dst, input logic [3:0] cm, input logic [1:0] cw);
        logic    op, mis;
        mem_wb_t e;
        acc_t    a;
        op  = v & (cm[0] | cm[1]);
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = op & (res[1:0] != 2'b00);
`endif
        if (v) begin
            e.valid    = 1'b1;
            e.reg_dest = dst;
            if (op && !mis) begin
                a.we = cm[1]; a.addr = res; a.wdata = wd;
                acc_q.push_back(a);
                if (cm[1]) mem[res] = wd;
                e.reg_write = !cm[1] && cw[0];
                e.value     = cw[1] ? model_rd(res) : res;
            end else begin
                e.reg_write = cw[0] && !mis;
                e.value     = res;
            end
            exp_q.push_back(e);
            mis_q.push_back(mis);
        end
        valid_in = v; result_in = res; write_data_in = wd;
        reg_dest_in = dst; ctrl_m_in = cm; ctrl_wb_in = cw;
        last_stall = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            last_stall++;
            if (last_stall > 50) begin
                check("stall_timeout", 64'(last_stall), 64'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Memory responder: checks the request against the reference order and holds ack for one cycle
    initial begin
        acc_t a;
        int   d;
        forever begin
            @(posedge clk); #1;
            if (resp_en && mem_req) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_req", 64'(mem_addr), 64'd0);
                    a.we = mem_we; a.addr = mem_addr; a.wdata = mem_wdata;
                end else begin
                    a = acc_q.pop_front();
                    check("req_we", 64'(mem_we), 64'(a.we));
                    check("req_addr", 64'(mem_addr), 64'(a.addr));
                    check("req_wdata", 64'(mem_wdata), 64'(a.wdata));
                end
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                repeat (d) begin
                    @(negedge clk);
                    check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata[30:0]},
                          {1'b1, a.we, a.addr, a.wdata[30:0]});
                    @(posedge clk); #1;
                end
                mem_ack = 1'b1;
                mem_rdata = model_rd(a.addr);
                @(posedge clk); #1;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                check("req_gap", 64'(mem_req), 64'd0);
            end
        end
    end

    // Monitor: every MEM/WB entry must match the head of the scoreboard
    initial begin
        mem_wb_t e;
        bit      m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wb", 64'(wb_value), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        m = mis_q.pop_front();
                        check("wb_reg_write", 64'(wb_reg_write), 64'(e.reg_write));
                        check("wb_reg_dest", 64'(wb_reg_dest), 64'(e.reg_dest));
                        check("wb_value", 64'(wb_value), 64'(e.value));
                        check("wb_misalign", 64'(misalign), 64'(m));
                    end
                end else begin
                    check("bubble_quiet", {62'd0, wb_reg_write, misalign}, 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {58'd0, stall, mem_req, mem_we, wb_valid, wb_reg_write, misalign}, 64'd0);
        check("reset_data", {mem_addr, mem_wdata}, 64'd0);
        check("reset_wb", {27'd0, wb_reg_dest, wb_value}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1'b1, 32'h1234, 32'h0, 5'd5, 4'b0000, 2'b01);
        check("alu_no_stall", 64'(last_stall), 64'd0);

        mem[32'h40] = 32'hDEAD_BEEF;
        fixed_delay = 3;
        issue(1'b1, 32'h40, 32'h1111, 5'd7, 4'b0001, 2'b11);
        check("load_stall_cycles", 64'(last_stall), 64'd4);

        fixed_delay = 1;
        issue(1'b1, 32'h80, 32'hA5A5_A5A5, 5'd9, 4'b0010, 2'b01);
        check("store_stall_cycles", 64'(last_stall), 64'd2);

        fixed_delay = 0;
        issue(1'b1, 32'h80, 32'h0, 5'd10, 4'b0001, 2'b11);
        check("b2b_first_stall", 64'(last_stall), 64'd1);
        issue(1'b1, 32'h40, 32'h0, 5'd11, 4'b0011, 2'b11);
        check("b2b_second_stall", 64'(last_stall), 64'd1);

        fixed_delay = -1;
        for (int i = 0; i < 200; i++) begin
            addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            issue($urandom_range(0, 9) != 0, addr, $urandom, 5'($urandom),
                  4'($urandom), 2'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        resp_en = 1'b0;
        valid_in = 1'b1; result_in = 32'h200; ctrl_m_in = 4'b0001; ctrl_wb_in = 2'b11;
        @(posedge clk); #1;
        check("rst_req_up", 64'(mem_req), 64'd1);
        #2;
        rst = 1'b1;
        valid_in = 1'b0;
        #1;
        check("rst_drops", {62'd0, mem_req, stall}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("rst_late_ack", {62'd0, wb_valid, mem_req}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queues_drained", 64'(exp_q.size() + acc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
